// File: rtl/dfg_sliced_ring_reg.sv
// Sliced rotating ring under a small load/run/done FSM, plus an independent
// registered cross-coupled mux lane ring. Every feedback path goes through a flop.
module dfg_sliced_ring_reg #(
  parameter int SLICE_W  = 2,
  parameter int N_SLICES = 5,
  parameter int N_CH     = 2,
  localparam int WIDTH   = SLICE_W * N_SLICES,
  localparam int CW      = $clog2(N_SLICES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             rot_en,
  input  logic             rot_dir,
  input  logic             abort,
  output logic [WIDTH-1:0] ring_q,
  output logic [CW-1:0]    rot_cnt,
  output logic             done,
  input  logic [N_CH-1:0]  ch_in,
  input  logic [N_CH-1:0]  ch_sel,
  output logic [N_CH-1:0]  ch_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r;

  function automatic logic [WIDTH-1:0] rot_up(input logic [WIDTH-1:0] v);
    return {v[WIDTH-SLICE_W-1:0], v[WIDTH-1:WIDTH-SLICE_W]};
  endfunction

  function automatic logic [WIDTH-1:0] rot_dn(input logic [WIDTH-1:0] v);
    return {v[SLICE_W-1:0], v[WIDTH-1:SLICE_W]};
  endfunction

  localparam logic [CW-1:0] LAST_CNT = CW'(N_SLICES - 1);

  // load_ready is the only output allowed to depend combinationally on state
  assign load_ready = (state_r == IDLE);

  // FSM, ring contents, rotation count and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ring_q  <= '0;
      rot_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load_valid) begin
            ring_q  <= load_data;
            rot_cnt <= '0;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          // abort takes priority so a final step cannot sneak a done pulse through
          if (abort) begin
            rot_cnt <= '0;
            state_r <= IDLE;
          end else if (rot_en) begin
            ring_q <= rot_dir ? rot_dn(ring_q) : rot_up(ring_q);
            if (rot_cnt == LAST_CNT) begin
              rot_cnt <= '0;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              rot_cnt <= rot_cnt + 1'b1;
            end
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          rot_cnt <= '0;
          state_r <= IDLE;
        end
        default: begin
          rot_cnt <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Cross-coupled lane ring: each lane takes its input or its neighbour's output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_out <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        ch_out[i] <= ch_sel[i] ? ch_in[i] : ch_out[(i + 1) % N_CH];
      end
    end
  end

endmodule

// File: tb/tb_dfg_sliced_ring_reg.sv
// Directed, table-driven bench for dfg_sliced_ring_reg (SLICE_W=2, N_SLICES=5, N_CH=2)
// plus hand-written sequences for done timing and asynchronous reset mid-run.
module tb_dfg_sliced_ring_reg;
  localparam int SW = 2;
  localparam int NS = 5;
  localparam int NC = 2;
  localparam int W  = SW * NS;
  localparam int CW = $clog2(NS);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_valid;
  logic [W-1:0]  load_data;
  logic          load_ready;
  logic          rot_en;
  logic          rot_dir;
  logic          abort;
  logic [W-1:0]  ring_q;
  logic [CW-1:0] rot_cnt;
  logic          done;
  logic [NC-1:0] ch_in;
  logic [NC-1:0] ch_sel;
  logic [NC-1:0] ch_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          lv;
    logic [W-1:0]  ld;
    logic          re;
    logic          rd;
    logic          ab;
    logic [NC-1:0] cs;
    logic [NC-1:0] ci;
    logic [W-1:0]  e_ring;
    logic [CW-1:0] e_cnt;
    logic          e_done;
    logic          e_ready;
    logic [NC-1:0] e_ch;
  } vec_t;

  vec_t vecs[$];

  dfg_sliced_ring_reg #(.SLICE_W(SW), .N_SLICES(NS), .N_CH(NC)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .rot_en(rot_en), .rot_dir(rot_dir), .abort(abort),
    .ring_q(ring_q), .rot_cnt(rot_cnt), .done(done),
    .ch_in(ch_in), .ch_sel(ch_sel), .ch_out(ch_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic lv, input logic [W-1:0] ld, input logic re, input logic rd,
                     input logic ab, input logic [NC-1:0] cs, input logic [NC-1:0] ci,
                     input logic [W-1:0] e_ring, input logic [CW-1:0] e_cnt,
                     input logic e_done, input logic e_ready, input logic [NC-1:0] e_ch);
    vec_t v;
    v.lv = lv; v.ld = ld; v.re = re; v.rd = rd; v.ab = ab; v.cs = cs; v.ci = ci;
    v.e_ring = e_ring; v.e_cnt = e_cnt; v.e_done = e_done; v.e_ready = e_ready; v.e_ch = e_ch;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0; load_data = '0; rot_en = 1'b0; rot_dir = 1'b0; abort = 1'b0;
    ch_in = '0; ch_sel = '0;
  endtask

  initial begin
    int cyc;
    //   lv    ld        re    rd    ab    cs     ci     ring      cnt   done  ready ch
    add(1'b1, 10'h3A5, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 10'h3A5, 3'd0, 1'b0, 1'b0, 2'b01);
    add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 10'h297, 3'd1, 1'b0, 1'b0, 2'b11);
    add(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 2'b11, 2'b10, 10'h3A5, 3'd2, 1'b0, 1'b0, 2'b10);
    add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 10'h297, 3'd3, 1'b0, 1'b0, 2'b01);
    add(1'b1, 10'h0FF, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 10'h297, 3'd3, 1'b0, 1'b0, 2'b10);
    add(1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 10'h297, 3'd0, 1'b0, 1'b1, 2'b01);
    add(1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 10'h297, 3'd0, 1'b0, 1'b1, 2'b10);
    add(1'b1, 10'h3A5, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 10'h3A5, 3'd0, 1'b0, 1'b0, 2'b01);
    add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 10'h3A5, 3'd0, 1'b0, 1'b0, 2'b10);
    add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 10'h297, 3'd1, 1'b0, 1'b0, 2'b01);
    add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 10'h25E, 3'd2, 1'b0, 1'b0, 2'b10);
    add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 10'h17A, 3'd3, 1'b0, 1'b0, 2'b01);
    add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 10'h1E9, 3'd4, 1'b0, 1'b0, 2'b10);
    add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 10'h3A5, 3'd0, 1'b1, 1'b0, 2'b01);
    add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 10'h3A5, 3'd0, 1'b0, 1'b1, 2'b10);
    add(1'b1, 10'h3A5, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 10'h3A5, 3'd0, 1'b0, 1'b0, 2'b01);
    add(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 10'h1E9, 3'd1, 1'b0, 1'b0, 2'b10);
    add(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 10'h17A, 3'd2, 1'b0, 1'b0, 2'b01);
    add(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 10'h25E, 3'd3, 1'b0, 1'b0, 2'b10);
    add(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 10'h297, 3'd4, 1'b0, 1'b0, 2'b01);
    add(1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 10'h297, 3'd0, 1'b0, 1'b1, 2'b10);
    add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 10'h297, 3'd0, 1'b0, 1'b1, 2'b01);

    rst_n = 1'b0;
    idle_inputs();
    #12;
    check("reset ring_q", 32'(ring_q), 32'h0);
    check("reset rot_cnt", 32'(rot_cnt), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset ch_out", 32'(ch_out), 32'h0);
    check("reset load_ready", 32'(load_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      load_valid = vecs[i].lv; load_data = vecs[i].ld; rot_en = vecs[i].re;
      rot_dir = vecs[i].rd; abort = vecs[i].ab; ch_sel = vecs[i].cs; ch_in = vecs[i].ci;
      step();
      check($sformatf("vec%0d ring_q", i), 32'(ring_q), 32'(vecs[i].e_ring));
      check($sformatf("vec%0d rot_cnt", i), 32'(rot_cnt), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d load_ready", i), 32'(load_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d ch_out", i), 32'(ch_out), 32'(vecs[i].e_ch));
    end

    // done latency with rot_en held high from the load cycle onward
    idle_inputs();
    load_valid = 1'b1; load_data = 10'h0C3; rot_en = 1'b1;
    step();
    load_valid = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    check("done latency after load edge", 32'(cyc), 32'd5);
    check("ring after revolution", 32'(ring_q), 32'h0C3);
    rot_en = 1'b0;
    step();
    check("done one-cycle pulse", 32'(done), 32'h0);
    check("ready after done", 32'(load_ready), 32'h1);

    // asynchronous reset between clock edges in the middle of RUN
    load_valid = 1'b1; load_data = 10'h3A5; ch_sel = 2'b11; ch_in = 2'b11;
    step();
    load_valid = 1'b0; rot_en = 1'b1;
    step();
    step();
    check("pre-reset rot_cnt", 32'(rot_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async reset ring_q", 32'(ring_q), 32'h0);
    check("async reset rot_cnt", 32'(rot_cnt), 32'h0);
    check("async reset done", 32'(done), 32'h0);
    check("async reset ch_out", 32'(ch_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    rot_en = 1'b1;
    #1;
    check("ready after reset release", 32'(load_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("no done after reset %0d", k), 32'(done), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
